// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, constants and helpers for the programmable clock divider
//
// Contents:
//   state_e   : per-channel run state (IDLE, RUN)
//   MIN_DIV   : smallest divisor a Load may carry
//   ceil_half : high-phase length for a divisor, ceil(n/2)
package clk_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // High-phase length. An odd divisor gets the extra cycle in the high phase.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - one channel of the programmable clock divider
//
// Ports:
//   i_clk    in   1      input clock, rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_enable in   1      run enable, honoured only at period boundaries
//   i_load   in   1      one-cycle divisor load strobe
//   i_div    in   WIDTH  divisor carried by i_load
//   o_clk    out  1      registered divided clock
//   o_tick   out  1      one-cycle pulse on each o_clk rising edge
//   o_pend   out  1      accepted divisor waiting for the next wrap
//   o_err    out  1      one-cycle pulse for a Load with divisor < 2
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend,
  output logic             o_err
);

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;       // active divisor N
  logic [WIDTH-1:0] r_pend_div;  // pending divisor P
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;
  logic             r_err;

  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_wrap;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_nxt;

  assign w_load_ok  = i_load && (i_div >= MIN_DIV_W);
  assign w_load_bad = i_load && (i_div <  MIN_DIV_W);
  assign w_wrap     = (r_cnt == (r_div - ONE_W));
  assign w_half     = WIDTH'(ceil_half(32'(r_div)));
  // Only used when cnt < N-1, so it cannot overflow.
  assign w_cnt_nxt  = r_cnt + ONE_W;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= DEF_DIV_W;
      r_pend_div <= DEF_DIV_W;
      r_pend     <= 1'b0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err  <= w_load_bad;
      r_tick <= 1'b0;

      if (r_state == IDLE) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        // Nothing is running, so a legal Load can replace N straight away.
        // A Load also supersedes any divisor left pending from the last run.
        if (w_load_ok) begin
          r_div  <= i_div;
          r_pend <= 1'b0;
        end else if (i_enable && r_pend) begin
          r_div  <= r_pend_div;
          r_pend <= 1'b0;
        end
        if (i_enable) begin
          r_state <= RUN;
          r_clk   <= 1'b1;
          r_tick  <= 1'b1;
        end
      end else begin
        if (!w_wrap) begin
          r_cnt <= w_cnt_nxt;
          r_clk <= (w_cnt_nxt < w_half);
        end else if (i_enable) begin
          r_cnt  <= '0;
          r_clk  <= 1'b1;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_div  <= r_pend_div;
            r_pend <= 1'b0;
          end
        end else begin
          // The low phase has just finished, so stopping here never
          // truncates a pulse.
          r_state <= IDLE;
          r_cnt   <= '0;
          r_clk   <= 1'b0;
        end
        // Placed after the wrap handling so a Load on the wrap edge keeps
        // Pend set: the wrap consumed the old P, the new value waits.
        if (w_load_ok) begin
          r_pend_div <= i_div;
          r_pend     <= 1'b1;
        end
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;
  assign o_err  = r_err;

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock divider top
//
// Ports:
//   i_clk_in   in   1           input clock, rising edge
//   i_rst_n    in   1           asynchronous active-low reset
//   i_enable   in   N_CH        per-channel run enable
//   i_load     in   N_CH        per-channel one-cycle load strobe
//   i_div_in   in   N_CH*WIDTH  packed divisors, channel i at [i*WIDTH +: WIDTH]
//   o_clk_out  out  N_CH        registered divided clocks
//   o_tick     out  N_CH        one-cycle pulse on each o_clk_out rising edge
//   o_pend     out  N_CH        divisor pending for the next wrap
//   o_err      out  N_CH        one-cycle pulse for an illegal divisor load
module clk_div_prog #(
  parameter int N_CH        = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                  i_clk_in,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_enable,
  input  logic [N_CH-1:0]       i_load,
  input  logic [N_CH*WIDTH-1:0] i_div_in,
  output logic [N_CH-1:0]       o_clk_out,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_pend,
  output logic [N_CH-1:0]       o_err
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_core #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
      .i_clk    (i_clk_in),
      .i_rst_n  (i_rst_n),
      .i_enable (i_enable[g]),
      .i_load   (i_load[g]),
      .i_div    (i_div_in[g*WIDTH +: WIDTH]),
      .o_clk    (o_clk_out[g]),
      .o_tick   (o_tick[g]),
      .o_pend   (o_pend[g]),
      .o_err    (o_err[g])
    );
  end

endmodule
